// File: rtl/uart_text_cursor.sv
// -----------------------------------------------------------------------------
// uart_text_cursor
//
// Purpose:
//   Byte-to-screen write controller sitting between the UART receiver and the
//   write port of the 32x4 text RAM. Each received byte becomes at most one RAM
//   write, and the module keeps track of the text cursor. It handles printable
//   text, CR/LF (newline), backspace and form feed (clear screen). The cursor
//   position and the last accepted byte are exported for the seven-segment
//   display.
//
// Ports:
//   clk        in   1      system clock
//   reset      in   1      asynchronous, active-high reset
//   rx_valid   in   1      UART byte-ready (level or pulse); one byte per high period
//   rx_data    in   8      received byte, taken on the rx_valid rising edge
//   wr_en      out  1      RAM write strobe, one cycle per write
//   wr_row     out  ROW_W  RAM write row
//   wr_col     out  COL_W  RAM write column
//   wr_data    out  8      RAM write data
//   cur_row    out  ROW_W  cursor row
//   cur_col    out  COL_W  cursor column
//   last_byte  out  8      last accepted byte, control codes included
//   busy       out  1      high while a screen clear is running
//   drop_flag  out  1      sticky; a byte arrived while busy (cleared by reset)
//
// Configuration macro:
//   UART_TEXT_CLEAR_ON_RESET_EN - when defined, the screen is blanked once
//   after every reset release before any byte is accepted.
// -----------------------------------------------------------------------------
module uart_text_cursor #(
    parameter int         COLS  = 32,
    parameter int         ROWS  = 4,
    parameter int         COL_W = 5,
    parameter int         ROW_W = 2,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             wr_en,
    output logic [ROW_W-1:0] wr_row,
    output logic [COL_W-1:0] wr_col,
    output logic [7:0]       wr_data,
    output logic [ROW_W-1:0] cur_row,
    output logic [COL_W-1:0] cur_col,
    output logic [7:0]       last_byte,
    output logic             busy,
    output logic             drop_flag
);

    localparam int               IDX_W    = COL_W + ROW_W;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ROWS * COLS - 1);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t           state_q;
    logic             rx_valid_q;
    logic             wr_en_q;
    logic [ROW_W-1:0] wr_row_q;
    logic [COL_W-1:0] wr_col_q;
    logic [7:0]       wr_data_q;
    logic [ROW_W-1:0] cur_row_q;
    logic [COL_W-1:0] cur_col_q;
    logic [7:0]       last_byte_q;
    logic             busy_q;
    logic             drop_flag_q;
    logic [IDX_W-1:0] clr_idx_q;
`ifdef UART_TEXT_CLEAR_ON_RESET_EN
    logic             start_q;
`endif

    logic             byte_event_d;
    logic             is_print_d;
    logic             at_origin_d;
    logic [ROW_W-1:0] adv_row_d;
    logic [COL_W-1:0] adv_col_d;
    logic [ROW_W-1:0] bs_row_d;
    logic [COL_W-1:0] bs_col_d;

    // Candidate cursor positions for "advance" and "backspace". Both rely on
    // natural modulo wrap of the width-limited row/column fields, so the last
    // cell wraps to (0,0) and backspace from column 0 lands on COLS-1.
    always_comb begin
        byte_event_d = rx_valid & ~rx_valid_q;
        is_print_d   = (rx_data >= 8'h20) && (rx_data <= 8'h7E);
        at_origin_d  = (cur_row_q == '0) && (cur_col_q == '0);
        adv_col_d    = cur_col_q + COL_W'(1);
        adv_row_d    = (cur_col_q == COL_LAST) ? cur_row_q + ROW_W'(1) : cur_row_q;
        bs_col_d     = cur_col_q - COL_W'(1);
        bs_row_d     = (cur_col_q == '0) ? cur_row_q - ROW_W'(1) : cur_row_q;
    end

    // Single registered FSM: every output is a flop, and wr_en is a one-cycle
    // strobe that defaults low unless this edge produces a write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rx_valid_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_row_q    <= '0;
            wr_col_q    <= '0;
            wr_data_q   <= '0;
            cur_row_q   <= '0;
            cur_col_q   <= '0;
            last_byte_q <= '0;
            busy_q      <= 1'b0;
            drop_flag_q <= 1'b0;
            clr_idx_q   <= '0;
`ifdef UART_TEXT_CLEAR_ON_RESET_EN
            start_q     <= 1'b1;
`endif
        end else begin
            rx_valid_q <= rx_valid;
            wr_en_q    <= 1'b0;
            case (state_q)
                IDLE: begin
`ifdef UART_TEXT_CLEAR_ON_RESET_EN
                    // First cycle after reset release: kick off the power-up
                    // clear; a byte arriving on this very edge is dropped.
                    if (start_q) begin
                        start_q   <= 1'b0;
                        state_q   <= CLEAR;
                        clr_idx_q <= '0;
                        busy_q    <= 1'b1;
                        if (byte_event_d) begin
                            drop_flag_q <= 1'b1;
                        end
                    end else
`endif
                    if (byte_event_d) begin
                        last_byte_q <= rx_data;
                        if (is_print_d) begin
                            wr_en_q   <= 1'b1;
                            wr_row_q  <= cur_row_q;
                            wr_col_q  <= cur_col_q;
                            wr_data_q <= rx_data;
                            cur_row_q <= adv_row_d;
                            cur_col_q <= adv_col_d;
                        end else begin
                            case (rx_data)
                                8'h0D, 8'h0A: begin
                                    cur_col_q <= '0;
                                    cur_row_q <= cur_row_q + ROW_W'(1);
                                end
                                8'h08: begin
                                    // Backspace at the home cell is a no-op.
                                    if (!at_origin_d) begin
                                        wr_en_q   <= 1'b1;
                                        wr_row_q  <= bs_row_d;
                                        wr_col_q  <= bs_col_d;
                                        wr_data_q <= BLANK;
                                        cur_row_q <= bs_row_d;
                                        cur_col_q <= bs_col_d;
                                    end
                                end
                                8'h0C: begin
                                    state_q   <= CLEAR;
                                    clr_idx_q <= '0;
                                    busy_q    <= 1'b1;
                                end
                                default: begin
                                end
                            endcase
                        end
                    end
                end
                CLEAR: begin
                    // Row-major sweep: the upper index bits are the row and the
                    // lower bits the column, one blank written per cycle.
                    if (byte_event_d) begin
                        drop_flag_q <= 1'b1;
                    end
                    wr_en_q   <= 1'b1;
                    wr_row_q  <= clr_idx_q[COL_W +: ROW_W];
                    wr_col_q  <= clr_idx_q[COL_W-1:0];
                    wr_data_q <= BLANK;
                    clr_idx_q <= clr_idx_q + IDX_W'(1);
                    if (clr_idx_q == IDX_LAST) begin
                        cur_row_q <= '0;
                        cur_col_q <= '0;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_row    = wr_row_q;
    assign wr_col    = wr_col_q;
    assign wr_data   = wr_data_q;
    assign cur_row   = cur_row_q;
    assign cur_col   = cur_col_q;
    assign last_byte = last_byte_q;
    assign busy      = busy_q;
    assign drop_flag = drop_flag_q;

endmodule

// File: tb/tb_uart_text_cursor.sv
// -----------------------------------------------------------------------------
// tb_uart_text_cursor
//
// Purpose:
//   Self-checking bench for uart_text_cursor. The reference model keeps the
//   cursor as a single linear cell number (row*32 + col) and applies the
//   text-terminal rules with plain arithmetic; the RAM write port is recorded
//   by a monitor into a queue that each scenario inspects.
//
// Ports: none (top-level bench). Honours UART_TEXT_CLEAR_ON_RESET_EN.
// -----------------------------------------------------------------------------
module tb_uart_text_cursor;

    logic       clk;
    logic       reset;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       wr_en;
    logic [1:0] wr_row;
    logic [4:0] wr_col;
    logic [7:0] wr_data;
    logic [1:0] cur_row;
    logic [4:0] cur_col;
    logic [7:0] last_byte;
    logic       busy;
    logic       drop_flag;

    uart_text_cursor dut (
        .clk       (clk),
        .reset     (reset),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .wr_en     (wr_en),
        .wr_row    (wr_row),
        .wr_col    (wr_col),
        .wr_data   (wr_data),
        .cur_row   (cur_row),
        .cur_col   (cur_col),
        .last_byte (last_byte),
        .busy      (busy),
        .drop_flag (drop_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        int row;
        int col;
        int data;
        int cyc;
    } wr_t;

    wr_t wrQ[$];

    // Record every RAM write, sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (wr_en === 1'b1 && reset === 1'b0) begin
            wrQ.push_back('{int'(wr_row), int'(wr_col), int'(wr_data), cyc});
        end
    end

    // Reference model state: linear cursor cell and last accepted byte.
    int mPos  = 0;
    int mLast = 0;

    function automatic void modelByte(input int b, output bit ew, output int er,
                                      output int ec, output int ed);
        ew = 1'b0; er = 0; ec = 0; ed = 0;
        mLast = b;
        if (b >= 32 && b <= 126) begin
            ew = 1'b1; er = mPos / 32; ec = mPos % 32; ed = b;
            mPos = (mPos + 1) % 128;
        end else if (b == 13 || b == 10) begin
            mPos = ((mPos / 32 + 1) % 4) * 32;
        end else if (b == 8) begin
            if (mPos != 0) begin
                mPos = mPos - 1;
                ew = 1'b1; er = mPos / 32; ec = mPos % 32; ed = 32;
            end
        end
    endfunction

    function automatic int randomIgnored();
        int b;
        do b = int'($urandom_range(0, 255));
        while ((b >= 32 && b <= 126) || b == 8 || b == 10 || b == 12 || b == 13);
        return b;
    endfunction

    task automatic sendByte(input int b, input int hold);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'(b);
        repeat (hold) @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(negedge clk);
    endtask

    task automatic stepByte(input int b, input int hold, output int n, output wr_t w);
        wrQ.delete();
        sendByte(b, hold);
        n = wrQ.size();
        w = '{-1, -1, -1, -1};
        if (n > 0) w = wrQ[0];
    endtask

    task automatic releaseReset();
        int guard;
        @(negedge clk);
        reset = 1'b0;
`ifdef UART_TEXT_CLEAR_ON_RESET_EN
        @(negedge clk);
        guard = 0;
        while (busy !== 1'b0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if (guard >= 300) begin
            miscompares++;
            $display("[TB] FAIL power-up clear: busy still %b after %0d cycles, want 0", busy, guard);
        end
`else
        guard = 0;
`endif
        @(negedge clk);
        wrQ.delete();
        mPos  = 0;
        mLast = 0;
    endtask

    task automatic doReset();
        @(negedge clk);
        reset    = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        releaseReset();
    endtask

    task automatic test_reset();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reset    = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (wr_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset wr_en: got %b want 0", wr_en); end
        vectors++;
        if ({wr_row, wr_col, wr_data} !== 15'h0) begin
            miscompares++; $display("[TB] FAIL reset wr_addr/data: got %h want 0", {wr_row, wr_col, wr_data});
        end
        vectors++;
        if ({cur_row, cur_col} !== 7'h0) begin
            miscompares++; $display("[TB] FAIL reset cursor: got (%0d,%0d) want (0,0)", cur_row, cur_col);
        end
        vectors++;
        if (last_byte !== 8'h00) begin miscompares++; $display("[TB] FAIL reset last_byte: got %h want 00", last_byte); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset busy: got %b want 0", busy); end
        vectors++;
        if (drop_flag !== 1'b0) begin miscompares++; $display("[TB] FAIL reset drop_flag: got %b want 0", drop_flag); end
        releaseReset();
    endtask

    task automatic test_hold_level();
        bit ew; int er, ec, ed, n; wr_t w;
        doReset();
        modelByte(8'h41, ew, er, ec, ed);
        stepByte(8'h41, 10, n, w);
        vectors++;
        if (n !== 1 || w.row !== 0 || w.col !== 0 || w.data !== 8'h41) begin
            miscompares++;
            $display("[TB] FAIL held A: got %0d writes first (%0d,%0d,%h), want 1 write (0,0,41)", n, w.row, w.col, w.data);
        end
        vectors++;
        if ({cur_row, cur_col} !== 7'd1) begin
            miscompares++; $display("[TB] FAIL held A cursor: got (%0d,%0d) want (0,1)", cur_row, cur_col);
        end
        vectors++;
        if (last_byte !== 8'h41) begin miscompares++; $display("[TB] FAIL held A last_byte: got %h want 41", last_byte); end
    endtask

    task automatic test_printable();
        bit ew; int er, ec, ed, n, b; wr_t w;
        doReset();
        for (int i = 0; i < 32; i++) begin
            b = int'($urandom_range(32, 126));
            modelByte(b, ew, er, ec, ed);
            stepByte(b, int'($urandom_range(1, 4)), n, w);
            vectors++;
            if (n !== 1 || w.row !== er || w.col !== ec || w.data !== ed) begin
                miscompares++;
                $display("[TB] FAIL printable[%0d]: got %0d writes first (%0d,%0d,%h), want (%0d,%0d,%h)",
                         i, n, w.row, w.col, w.data, er, ec, ed);
            end
        end
        modelByte(8'h5A, ew, er, ec, ed);
        stepByte(8'h5A, 1, n, w);
        vectors++;
        if (n !== 1 || w.row !== 1 || w.col !== 0 || w.data !== 8'h5A) begin
            miscompares++;
            $display("[TB] FAIL row wrap Z: got %0d writes first (%0d,%0d,%h), want (1,0,5a)", n, w.row, w.col, w.data);
        end
        vectors++;
        if ({cur_row, cur_col} !== 7'd33) begin
            miscompares++; $display("[TB] FAIL row wrap cursor: got (%0d,%0d) want (1,1)", cur_row, cur_col);
        end
    endtask

    task automatic test_screen_wrap();
        bit ew; int er, ec, ed, n, b; wr_t w;
        doReset();
        for (int i = 0; i < 3; i++) begin
            b = (i == 0) ? 8'h0D : 8'h0A;
            modelByte(b, ew, er, ec, ed);
            stepByte(b, 2, n, w);
            vectors++;
            if (n !== 0) begin miscompares++; $display("[TB] FAIL newline[%0d]: got %0d writes want 0", i, n); end
        end
        for (int i = 0; i < 31; i++) begin
            b = int'($urandom_range(32, 126));
            modelByte(b, ew, er, ec, ed);
            stepByte(b, 1, n, w);
        end
        vectors++;
        if ({cur_row, cur_col} !== 7'd127) begin
            miscompares++; $display("[TB] FAIL reach (3,31): got (%0d,%0d) want (3,31)", cur_row, cur_col);
        end
        modelByte(8'h78, ew, er, ec, ed);
        stepByte(8'h78, 1, n, w);
        vectors++;
        if (n !== 1 || w.row !== 3 || w.col !== 31 || w.data !== 8'h78) begin
            miscompares++;
            $display("[TB] FAIL last cell x: got %0d writes first (%0d,%0d,%h), want (3,31,78)", n, w.row, w.col, w.data);
        end
        vectors++;
        if ({cur_row, cur_col} !== 7'd0) begin
            miscompares++; $display("[TB] FAIL screen wrap cursor: got (%0d,%0d) want (0,0)", cur_row, cur_col);
        end
    endtask

    task automatic test_backspace();
        bit ew; int er, ec, ed, n; wr_t w;
        doReset();
        modelByte(8'h0A, ew, er, ec, ed);
        stepByte(8'h0A, 1, n, w);
        modelByte(8'h08, ew, er, ec, ed);
        stepByte(8'h08, 3, n, w);
        vectors++;
        if (n !== 1 || w.row !== 0 || w.col !== 31 || w.data !== 8'h20) begin
            miscompares++;
            $display("[TB] FAIL bs row start: got %0d writes first (%0d,%0d,%h), want (0,31,20)", n, w.row, w.col, w.data);
        end
        vectors++;
        if ({cur_row, cur_col} !== 7'd31) begin
            miscompares++; $display("[TB] FAIL bs row start cursor: got (%0d,%0d) want (0,31)", cur_row, cur_col);
        end
        stepByte(8'h71, 1, n, w);
        stepByte(8'h72, 1, n, w);
        stepByte(8'h08, 1, n, w);
        vectors++;
        if (n !== 1 || w.row !== 1 || w.col !== 0 || w.data !== 8'h20) begin
            miscompares++;
            $display("[TB] FAIL bs mid row: got %0d writes first (%0d,%0d,%h), want (1,0,20)", n, w.row, w.col, w.data);
        end
        doReset();
        stepByte(8'h08, 2, n, w);
        vectors++;
        if (n !== 0) begin miscompares++; $display("[TB] FAIL bs at origin: got %0d writes want 0", n); end
        vectors++;
        if ({cur_row, cur_col} !== 7'd0 || last_byte !== 8'h08) begin
            miscompares++;
            $display("[TB] FAIL bs at origin state: got (%0d,%0d) last %h want (0,0) last 08", cur_row, cur_col, last_byte);
        end
        mPos  = 0;
        mLast = 8;
    endtask

    task automatic test_ignored();
        bit ew; int er, ec, ed, n, b; wr_t w;
        doReset();
        stepByte(8'h61, 1, n, w);
        modelByte(8'h61, ew, er, ec, ed);
        for (int i = 0; i < 10; i++) begin
            b = randomIgnored();
            modelByte(b, ew, er, ec, ed);
            stepByte(b, int'($urandom_range(1, 3)), n, w);
            vectors++;
            if (n !== 0 || {cur_row, cur_col} !== 7'(mPos) || last_byte !== 8'(b)) begin
                miscompares++;
                $display("[TB] FAIL ignored %h: got %0d writes cursor (%0d,%0d) last %h, want 0 writes (%0d,%0d) last %h",
                         b, n, cur_row, cur_col, last_byte, mPos / 32, mPos % 32, b);
            end
        end
    endtask

    task automatic test_random_stream();
        bit ew; int er, ec, ed, n, b, kind; wr_t w;
        doReset();
        for (int i = 0; i < 100; i++) begin
            kind = int'($urandom_range(0, 9));
            if (kind < 5)       b = int'($urandom_range(32, 126));
            else if (kind == 5) b = ($urandom_range(0, 1) == 0) ? 13 : 10;
            else if (kind < 9)  b = 8;
            else                b = randomIgnored();
            modelByte(b, ew, er, ec, ed);
            stepByte(b, int'($urandom_range(1, 3)), n, w);
            vectors++;
            if (n !== (ew ? 1 : 0) || (ew && (w.row !== er || w.col !== ec || w.data !== ed))) begin
                miscompares++;
                $display("[TB] FAIL stream[%0d] byte %h: got %0d writes first (%0d,%0d,%h), want %0d (%0d,%0d,%h)",
                         i, b, n, w.row, w.col, w.data, ew, er, ec, ed);
            end
            vectors++;
            if ({cur_row, cur_col} !== 7'(mPos) || last_byte !== 8'(mLast)) begin
                miscompares++;
                $display("[TB] FAIL stream[%0d] state: got (%0d,%0d) last %h, want (%0d,%0d) last %h",
                         i, cur_row, cur_col, last_byte, mPos / 32, mPos % 32, mLast);
            end
        end
    endtask

    task automatic test_clear();
        int guard, bad, n; wr_t w;
        wrQ.delete();
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'h0C;
        @(negedge clk);
        rx_valid = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL clear start busy: got %b want 1", busy); end
        repeat (3) @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'h41;
        repeat (2) @(negedge clk);
        rx_valid = 1'b0;
        guard = 0;
        while (busy !== 1'b0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if (guard >= 300) begin miscompares++; $display("[TB] FAIL clear end: busy %b after %0d cycles, want 0", busy, guard); end
        repeat (2) @(negedge clk);
        vectors++;
        if (wrQ.size() !== 128) begin
            miscompares++; $display("[TB] FAIL clear write count: got %0d want 128", wrQ.size());
        end
        bad = 0;
        for (int i = 0; i < wrQ.size() && i < 128; i++) begin
            if (wrQ[i].row !== i / 32 || wrQ[i].col !== i % 32 || wrQ[i].data !== 32) bad++;
        end
        vectors++;
        if (bad !== 0) begin miscompares++; $display("[TB] FAIL clear order: got %0d bad cells want 0", bad); end
        vectors++;
        if (wrQ.size() == 0 || wrQ[wrQ.size() - 1].cyc - wrQ[0].cyc !== 127) begin
            miscompares++; $display("[TB] FAIL clear contiguity: writes not in 128 consecutive cycles (count %0d)", wrQ.size());
        end
        vectors++;
        if (drop_flag !== 1'b1 || {cur_row, cur_col} !== 7'd0 || last_byte !== 8'h0C) begin
            miscompares++;
            $display("[TB] FAIL after clear: got drop %b cursor (%0d,%0d) last %h, want drop 1 (0,0) last 0c",
                     drop_flag, cur_row, cur_col, last_byte);
        end
        mPos  = 0;
        mLast = 12;
        stepByte(8'h41, 1, n, w);
        vectors++;
        if (n !== 1 || w.row !== 0 || w.col !== 0 || w.data !== 8'h41 || drop_flag !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL post-clear A: got %0d writes first (%0d,%0d,%h) drop %b, want (0,0,41) drop 1",
                     n, w.row, w.col, w.data, drop_flag);
        end
    endtask

    task automatic test_reset_mid_clear();
        int guard, n; wr_t w;
        wrQ.delete();
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'h0C;
        @(negedge clk);
        rx_valid = 1'b0;
        guard = 0;
        while (wrQ.size() < 50 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if (guard >= 200) begin miscompares++; $display("[TB] FAIL mid-clear reach: got %0d writes want 50", wrQ.size()); end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({wr_en, wr_row, wr_col, wr_data, cur_row, cur_col, last_byte, busy, drop_flag} !== 33'h0) begin
            miscompares++;
            $display("[TB] FAIL mid-clear reset: got wr_en %b busy %b drop %b last %h cursor (%0d,%0d), want all 0",
                     wr_en, busy, drop_flag, last_byte, cur_row, cur_col);
        end
        repeat (2) @(negedge clk);
        wrQ.delete();
        reset = 1'b0;
`ifdef UART_TEXT_CLEAR_ON_RESET_EN
        repeat (140) @(negedge clk);
        vectors++;
        if (wrQ.size() !== 128 || busy !== 1'b0) begin
            miscompares++; $display("[TB] FAIL restart clear: got %0d writes busy %b, want 128 busy 0", wrQ.size(), busy);
        end
`else
        repeat (20) @(negedge clk);
        vectors++;
        if (wrQ.size() !== 0 || busy !== 1'b0) begin
            miscompares++; $display("[TB] FAIL after abort: got %0d writes busy %b, want 0 busy 0", wrQ.size(), busy);
        end
`endif
        stepByte(8'h42, 1, n, w);
        vectors++;
        if (n !== 1 || w.row !== 0 || w.col !== 0 || w.data !== 8'h42) begin
            miscompares++;
            $display("[TB] FAIL idle after abort: got %0d writes first (%0d,%0d,%h), want (0,0,42)", n, w.row, w.col, w.data);
        end
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        test_reset();
        test_hold_level();
        test_printable();
        test_screen_wrap();
        test_backspace();
        test_ignored();
        test_random_stream();
        test_clear();
        test_reset_mid_clear();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
